// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : single-port word RAM serving I-fetch / D-access with wait states
// Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        busy
);

  localparam int         DEPTH   = 2 ** AW;
  localparam logic [3:0] LAT_C   = 4'(LAT);
  localparam logic       NO_WAIT = (LAT == 0);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2} state_t;
  typedef enum logic [1:0] {SEL_I = 2'd0, SEL_DR = 2'd1, SEL_DW = 2'd2} sel_t;

  state_t        state_q;
  sel_t          sel_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem_q [DEPTH];

  sel_t          w_req_sel;
  logic [AW-1:0] w_req_idx;
  sel_t          w_load_sel;
  logic [AW-1:0] w_load_idx;
  logic [31:0]   w_rdata;
  logic          w_any_req;
  logic          w_held;
  logic          w_enter;
  logic          w_write;
  logic          w_unused;

  assign w_any_req = iREN | dREN | dWEN;
  assign w_unused  = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};

  // Data side wins over instruction fetch; a simultaneous read+write is a write.
  always_comb begin
    w_req_sel = SEL_I;
    w_req_idx = iaddr[AW+1:2];
    if (dWEN) begin
      w_req_sel = SEL_DW;
      w_req_idx = daddr[AW+1:2];
    end else if (dREN) begin
      w_req_sel = SEL_DR;
      w_req_idx = daddr[AW+1:2];
    end
  end

  always_comb begin
    case (sel_q)
      SEL_I:   w_held = iREN;
      SEL_DR:  w_held = dREN;
      default: w_held = dWEN;
    endcase
  end

  assign w_enter    = (state_q == IDLE && w_any_req && NO_WAIT) ||
                      (state_q == WAIT && w_held && cnt_q == 4'd1);
  assign w_load_sel = (state_q == IDLE) ? w_req_sel : sel_q;
  assign w_load_idx = (state_q == IDLE) ? w_req_idx : idx_q;
  assign w_rdata    = mem_q[w_load_idx];
  assign w_write    = (state_q == ACCESS) && (sel_q == SEL_DW) && dWEN;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      sel_q    <= SEL_I;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      imemload <= 32'd0;
      dmemload <= 32'd0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      // Hits and load words are registered on the edge that enters ACCESS.
      if (w_enter) begin
        ihit <= (w_load_sel == SEL_I);
        dhit <= (w_load_sel != SEL_I);
        if (w_load_sel == SEL_I)  imemload <= w_rdata;
        if (w_load_sel == SEL_DR) dmemload <= w_rdata;
      end
      case (state_q)
        IDLE: begin
          if (w_any_req) begin
            sel_q   <= w_req_sel;
            idx_q   <= w_req_idx;
            wdata_q <= dstore;
            cnt_q   <= LAT_C;
            state_q <= NO_WAIT ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (!w_held)             state_q <= IDLE;
          else if (cnt_q == 4'd1)  state_q <= ACCESS;
          else                     cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A write commits on the edge leaving ACCESS only if dWEN is still held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (w_write) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// Self-checking bench for mem_responder: one LAT=2 and one LAT=0 instance,
// expected hits queued on a scoreboard and popped when the DUT answers.
module tb_mem_responder;

  localparam int K_NONE = 0;
  localparam int K_I    = 1;
  localparam int K_DR   = 2;
  localparam int K_DW   = 3;
  localparam int K_DRW  = 4;
  localparam int LAT2   = 2;

  typedef struct {
    logic        hi;
    logic [31:0] iload;
    logic [31:0] dload;
  } exp_t;

  typedef struct {
    int          lat;
    logic        hi;
    logic        hd;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        hi_nx;
    logic        hd_nx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        iren2, dren2, dwen2, ihit2, dhit2, busy2;
  logic [31:0] iaddr2, daddr2, dstore2, imem2, dmem2;
  logic        iren0, dren0, dwen0, ihit0, dhit0, busy0;
  logic [31:0] iaddr0, daddr0, dstore0, imem0, dmem0;

  exp_t        sb[$];
  logic [31:0] mdl [2][256];
  logic [31:0] ild [2];
  logic [31:0] dld [2];
  int          total;
  int          passed;
  int          both_cnt = 0;

  mem_responder #(.LAT(2), .AW(8)) u_dut2 (
    .CLK(clk), .RST(rst), .iREN(iren2), .iaddr(iaddr2), .dREN(dren2), .dWEN(dwen2),
    .daddr(daddr2), .dstore(dstore2), .ihit(ihit2), .imemload(imem2), .dhit(dhit2),
    .dmemload(dmem2), .busy(busy2)
  );

  mem_responder #(.LAT(0), .AW(8)) u_dut0 (
    .CLK(clk), .RST(rst), .iREN(iren0), .iaddr(iaddr0), .dREN(dren0), .dWEN(dwen0),
    .daddr(daddr0), .dstore(dstore0), .ihit(ihit0), .imemload(imem0), .dhit(dhit0),
    .dmemload(dmem0), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ihit2 && dhit2) both_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      ild[u] = '0;
      dld[u] = '0;
      for (int i = 0; i < 256; i++) mdl[u][i] = '0;
    end
  endtask

  task automatic drive(input int u, input int kind, input logic [31:0] a, input logic [31:0] w);
    logic ir, dr, dw;
    ir = (kind == K_I);
    dr = (kind == K_DR) || (kind == K_DRW);
    dw = (kind == K_DW) || (kind == K_DRW);
    if (u == 1) begin
      iren0 = ir; dren0 = dr; dwen0 = dw; iaddr0 = a; daddr0 = a; dstore0 = w;
    end else begin
      iren2 = ir; dren2 = dr; dwen2 = dw; iaddr2 = a; daddr2 = a; dstore2 = w;
    end
  endtask

  // Reference model: computes what the next hit must show and queues it.
  task automatic push_exp(input int u, input int kind, input logic [31:0] a, input logic [31:0] w);
    exp_t       e;
    logic [7:0] ix;
    ix   = a[9:2];
    e.hi = (kind == K_I);
    if (kind == K_I)  ild[u] = mdl[u][ix];
    if (kind == K_DR) dld[u] = mdl[u][ix];
    e.iload = ild[u];
    e.dload = dld[u];
    if (kind == K_DW || kind == K_DRW) mdl[u][ix] = w;
    sb.push_back(e);
  endtask

  // Holds a request until a hit (bounded), keeps it over the edge leaving ACCESS, then drops it.
  task automatic txn(input int u, input int kind, input logic [31:0] a, input logic [31:0] w,
                     output obs_t o);
    o.lat = -1; o.hi = 1'b0; o.hd = 1'b0; o.iload = '0; o.dload = '0;
    o.hi_nx = 1'b0; o.hd_nx = 1'b0;
    drive(u, kind, a, w);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (((u == 1) ? (ihit0 | dhit0) : (ihit2 | dhit2)) == 1'b1) begin
        o.lat   = k;
        o.hi    = (u == 1) ? ihit0 : ihit2;
        o.hd    = (u == 1) ? dhit0 : dhit2;
        o.iload = (u == 1) ? imem0 : imem2;
        o.dload = (u == 1) ? dmem0 : dmem2;
        break;
      end
    end
    tick();
    o.hi_nx = (u == 1) ? ihit0 : ihit2;
    o.hd_nx = (u == 1) ? dhit0 : dhit2;
    drive(u, K_NONE, '0, '0);
  endtask

  task automatic test_reset();
    drive(0, K_NONE, '0, '0);
    drive(1, K_NONE, '0, '0);
    model_reset();
    tick(); tick();
    total++; if (busy2 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy2); else passed++;
    total++; if (ihit2 !== 1'b0 || dhit2 !== 1'b0) $display("FAIL rst_hits: got i=%b d=%b want 0", ihit2, dhit2); else passed++;
    total++; if (imem2 !== 32'h0) $display("FAIL rst_imemload: got %h want 0", imem2); else passed++;
    total++; if (dmem2 !== 32'h0) $display("FAIL rst_dmemload: got %h want 0", dmem2); else passed++;
    total++; if ({busy0, ihit0, dhit0} !== 3'b000) $display("FAIL rst_lat0_flags: got %b want 000", {busy0, ihit0, dhit0}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_ifetch();
    obs_t o; exp_t e;
    push_exp(0, K_DW, 32'h0, 32'h3C01_0004);
    txn(0, K_DW, 32'h0, 32'h3C01_0004, o);
    e = sb.pop_front();
    total++; if (o.lat !== LAT2) $display("FAIL preload_lat: got %0d want %0d", o.lat, LAT2); else passed++;
    total++; if (o.hd !== 1'b1 || o.hi !== e.hi) $display("FAIL preload_hit: got i=%b d=%b want i=0 d=1", o.hi, o.hd); else passed++;
    push_exp(0, K_I, 32'h0, '0);
    txn(0, K_I, 32'h0, '0, o);
    e = sb.pop_front();
    total++; if (o.lat !== LAT2) $display("FAIL ifetch_lat: got %0d want %0d", o.lat, LAT2); else passed++;
    total++; if (o.hi !== e.hi || o.hd !== 1'b0) $display("FAIL ifetch_hit: got i=%b d=%b want i=1 d=0", o.hi, o.hd); else passed++;
    total++; if (o.iload !== e.iload) $display("FAIL ifetch_data: got %h want %h", o.iload, e.iload); else passed++;
    total++; if (o.hi_nx !== 1'b0) $display("FAIL ifetch_pulse: got %b want 0", o.hi_nx); else passed++;
  endtask

  task automatic test_raw_wrap();
    obs_t o; exp_t e;
    push_exp(0, K_DW, 32'h20, 32'h1234_5678);
    txn(0, K_DW, 32'h20, 32'h1234_5678, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload) $display("FAIL write_dmemload: got %h want %h", o.dload, e.dload); else passed++;
    push_exp(0, K_DR, 32'h20, '0);
    txn(0, K_DR, 32'h20, '0, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload || o.hd !== 1'b1) $display("FAIL raw_read: got %h hit=%b want %h hit=1", o.dload, o.hd, e.dload); else passed++;
    push_exp(0, K_DR, 32'h420, '0);
    txn(0, K_DR, 32'h420, '0, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload) $display("FAIL wrap_read: got %h want %h", o.dload, e.dload); else passed++;
  endtask

  task automatic test_arbitration();
    exp_t e;
    int kd, ki;
    kd = -1; ki = -1;
    push_exp(0, K_DR, 32'h20, '0);
    push_exp(0, K_I, 32'h0, '0);
    iren2 = 1'b1; iaddr2 = 32'h0; dren2 = 1'b1; daddr2 = 32'h20;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (kd >= 0 && dren2) dren2 = 1'b0;
      if (dhit2) begin
        kd = k;
        if (sb.size() == 0) begin
          total++; $display("FAIL arb_extra_dhit: got hit at %0d want none", k);
        end else begin
          e = sb.pop_front();
          total++; if (ihit2 !== e.hi) $display("FAIL arb_first: got ihit=%b want %b", ihit2, e.hi); else passed++;
          total++; if (dmem2 !== e.dload) $display("FAIL arb_ddata: got %h want %h", dmem2, e.dload); else passed++;
        end
      end
      if (ihit2) begin
        ki = k;
        if (sb.size() == 0) begin
          total++; $display("FAIL arb_extra_ihit: got hit at %0d want none", k);
        end else begin
          e = sb.pop_front();
          total++; if (imem2 !== e.iload) $display("FAIL arb_idata: got %h want %h", imem2, e.iload); else passed++;
        end
      end
      if (ki >= 0) break;
    end
    tick();
    drive(0, K_NONE, '0, '0);
    total++; if (kd !== LAT2) $display("FAIL arb_dlat: got %0d want %0d", kd, LAT2); else passed++;
    total++; if (ki - kd !== LAT2 + 2) $display("FAIL arb_gap: got %0d want %0d", ki - kd, LAT2 + 2); else passed++;
    total++; if (both_cnt !== 0) $display("FAIL arb_both_hits: got %0d want 0", both_cnt); else passed++;
  endtask

  task automatic test_abort_wait();
    int seen;
    seen = 0;
    drive(0, K_DR, 32'h0, '0);
    tick();
    total++; if (busy2 !== 1'b1) $display("FAIL abortw_busy_on: got %b want 1", busy2); else passed++;
    drive(0, K_NONE, '0, '0);
    tick();
    total++; if (busy2 !== 1'b0) $display("FAIL abortw_idle: got %b want 0", busy2); else passed++;
    for (int k = 0; k < 5; k++) begin
      if (dhit2) seen++;
      tick();
    end
    total++; if (seen !== 0) $display("FAIL abortw_dhit: got %0d hits want 0", seen); else passed++;
    total++; if (dmem2 !== dld[0]) $display("FAIL abortw_dmemload: got %h want %h", dmem2, dld[0]); else passed++;
  endtask

  task automatic test_abort_access();
    obs_t o; exp_t e;
    drive(0, K_DW, 32'h20, 32'hCAFE_F00D);
    tick(); tick(); tick();
    total++; if (dhit2 !== 1'b1) $display("FAIL aborta_in_access: got dhit=%b want 1", dhit2); else passed++;
    drive(0, K_NONE, '0, '0);
    tick(); tick();
    push_exp(0, K_DR, 32'h20, '0);
    txn(0, K_DR, 32'h20, '0, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload) $display("FAIL aborta_no_write: got %h want %h", o.dload, e.dload); else passed++;
  endtask

  task automatic test_rw_both();
    obs_t o; exp_t e;
    push_exp(0, K_DRW, 32'h40, 32'hA5A5_0F0F);
    txn(0, K_DRW, 32'h40, 32'hA5A5_0F0F, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload || o.hd !== 1'b1) $display("FAIL rw_dmemload: got %h hit=%b want %h hit=1", o.dload, o.hd, e.dload); else passed++;
    push_exp(0, K_DR, 32'h40, '0);
    txn(0, K_DR, 32'h40, '0, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload) $display("FAIL rw_is_write: got %h want %h", o.dload, e.dload); else passed++;
  endtask

  task automatic test_lat0();
    obs_t o; exp_t e;
    push_exp(1, K_DW, 32'h4, 32'h0BAD_F00D);
    txn(1, K_DW, 32'h4, 32'h0BAD_F00D, o);
    e = sb.pop_front();
    total++; if (o.lat !== 0) $display("FAIL lat0_wlat: got %0d want 0", o.lat); else passed++;
    push_exp(1, K_DR, 32'h4, '0);
    txn(1, K_DR, 32'h4, '0, o);
    e = sb.pop_front();
    total++; if (o.lat !== 0) $display("FAIL lat0_rlat: got %0d want 0", o.lat); else passed++;
    total++; if (o.dload !== e.dload) $display("FAIL lat0_data: got %h want %h", o.dload, e.dload); else passed++;
    total++; if (o.hd_nx !== 1'b0) $display("FAIL lat0_pulse: got %b want 0", o.hd_nx); else passed++;
  endtask

  task automatic test_reset_midwait();
    obs_t o; exp_t e;
    drive(0, K_DW, 32'h10, 32'hDEAD_BEEF);
    tick(); tick();
    total++; if (busy2 !== 1'b1) $display("FAIL rstw_pre_busy: got %b want 1", busy2); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (busy2 !== 1'b0) $display("FAIL rstw_busy: got %b want 0", busy2); else passed++;
    total++; if ({ihit2, dhit2} !== 2'b00) $display("FAIL rstw_hits: got %b want 00", {ihit2, dhit2}); else passed++;
    total++; if (dmem2 !== 32'h0 || imem2 !== 32'h0) $display("FAIL rstw_loads: got i=%h d=%h want 0", imem2, dmem2); else passed++;
    drive(0, K_NONE, '0, '0);
    #1 rst = 1'b0;
    model_reset();
    push_exp(0, K_DR, 32'h10, '0);
    txn(0, K_DR, 32'h10, '0, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload || o.lat !== LAT2) $display("FAIL rstw_no_write: got %h lat=%0d want %h lat=%0d", o.dload, o.lat, e.dload, LAT2); else passed++;
    push_exp(0, K_I, 32'h0, '0);
    txn(0, K_I, 32'h0, '0, o);
    e = sb.pop_front();
    total++; if (o.iload !== e.iload) $display("FAIL rstw_ram_clear: got %h want %h", o.iload, e.iload); else passed++;
    push_exp(1, K_DR, 32'h4, '0);
    txn(1, K_DR, 32'h4, '0, o);
    e = sb.pop_front();
    total++; if (o.dload !== e.dload) $display("FAIL rstw_lat0_clear: got %h want %h", o.dload, e.dload); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_ifetch();
    test_raw_wrap();
    test_arbitration();
    test_abort_wait();
    test_abort_access();
    test_rw_both();
    test_lat0();
    test_reset_midwait();
    total++; if (sb.size() !== 0) $display("FAIL sb_drained: got %0d left want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
